// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU among NUM_REQ requesters.
// Winner is latched in IDLE, drives the ALU in ISSUE, and the screened result is held in RESP.
module alu_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int OP_W    = 4,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*OP_W-1:0]   req_op,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic [OP_W-1:0]           alu_ctrl,
  output logic [DATA_W-1:0]         alu_a,
  output logic [DATA_W-1:0]         alu_b,
  input  logic [DATA_W-1:0]         alu_result,
  input  logic                      alu_zero,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_result,
  output logic                      rsp_zero,
  output logic                      rsp_err,
  output logic                      busy,
  output logic [CNT_W-1:0]          op_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  localparam logic [ID_W-1:0] LAST_INIT = ID_W'(NUM_REQ - 1);
  localparam logic [OP_W-1:0] OP_ILL_LO = '0;
  localparam logic [OP_W-1:0] OP_ILL_HI = '1;
  localparam logic [OP_W-1:0] OP_DIV    = OP_W'(4);

  state_t state, state_next;

  logic [ID_W-1:0]   last_grant;
  logic [ID_W-1:0]   winner, hi_idx, lo_idx;
  logic              hi_found, lo_found;
  logic              accept, handshake, screen_err;

  logic [OP_W-1:0]   sel_op, lat_op;
  logic [DATA_W-1:0] sel_a, sel_b, lat_a, lat_b;
  logic [ID_W-1:0]   lat_id;

  // First valid index above last_grant wins; otherwise wrap to the lowest valid index.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i]) begin
        if (!hi_found && (i > int'(last_grant))) begin
          hi_found = 1'b1;
          hi_idx   = ID_W'(i);
        end
        if (!lo_found) begin
          lo_found = 1'b1;
          lo_idx   = ID_W'(i);
        end
      end
    end
    winner = hi_found ? hi_idx : lo_idx;
  end

  assign accept    = (state == IDLE) && lo_found;
  assign handshake = (state == RESP) && rsp_valid && rsp_ready;

  always_comb begin
    sel_op    = '0;
    sel_a     = '0;
    sel_b     = '0;
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == winner) begin
        sel_op       = req_op[i*OP_W +: OP_W];
        sel_a        = req_a[i*DATA_W +: DATA_W];
        sel_b        = req_b[i*DATA_W +: DATA_W];
        req_ready[i] = accept;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (lo_found) state_next = ISSUE;
      ISSUE:   state_next = RESP;
      RESP:    if (handshake) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_op <= '0;
      lat_a  <= '0;
      lat_b  <= '0;
      lat_id <= '0;
    end else if (accept) begin
      lat_op <= sel_op;
      lat_a  <= sel_a;
      lat_b  <= sel_b;
      lat_id <= winner;
    end
  end

  // The ALU still sees screened operations; only the captured response is overridden.
  assign screen_err = (lat_op == OP_ILL_LO) || (lat_op == OP_ILL_HI) ||
                      ((lat_op == OP_DIV) && (lat_b == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
      last_grant <= LAST_INIT;
      op_count   <= '0;
    end else if (state == ISSUE) begin
      rsp_valid <= 1'b1;
      rsp_id    <= lat_id;
      if (screen_err) begin
        rsp_result <= '0;
        rsp_zero   <= 1'b1;
        rsp_err    <= 1'b1;
      end else begin
        rsp_result <= alu_result;
        rsp_zero   <= alu_zero;
        rsp_err    <= 1'b0;
      end
    end else if (handshake) begin
      rsp_valid  <= 1'b0;
      last_grant <= rsp_id;
      op_count   <= op_count + CNT_W'(1);
    end
  end

  assign alu_ctrl = (state == ISSUE) ? lat_op : '0;
  assign alu_a    = (state == ISSUE) ? lat_a  : '0;
  assign alu_b    = (state == ISSUE) ? lat_b  : '0;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a small behavioural ALU model.
// Unsupported ALU cases return 0xDEADBEEF so screening overrides are visible.
module tb_alu_share_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 32;
  localparam int OP_W    = 4;
  localparam int ID_W    = 2;
  localparam int CNT_W   = 16;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*OP_W-1:0]   req_op;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic [OP_W-1:0]           alu_ctrl;
  logic [DATA_W-1:0]         alu_a;
  logic [DATA_W-1:0]         alu_b;
  logic [DATA_W-1:0]         alu_result;
  logic                      alu_zero;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [ID_W-1:0]           rsp_id;
  logic [DATA_W-1:0]         rsp_result;
  logic                      rsp_zero;
  logic                      rsp_err;
  logic                      busy;
  logic [CNT_W-1:0]          op_count;

  int checks;
  int errors;
  int exp_id;

  alu_share_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .OP_W(OP_W), .ID_W(ID_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (alu_ctrl)
      4'b0001: alu_result = alu_a + alu_b;
      4'b0010: alu_result = alu_a - alu_b;
      4'b0011: alu_result = alu_a * alu_b;
      4'b0100: alu_result = (alu_b == 0) ? 32'hDEADBEEF : alu_a / alu_b;
      4'b0111: alu_result = alu_a ^ alu_b;
      default: alu_result = 32'hDEADBEEF;
    endcase
    alu_zero = (alu_result == 0);
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic v, input logic [3:0] op,
                               input logic [31:0] a, input logic [31:0] b);
    req_valid[idx]               = v;
    req_op[idx*OP_W +: OP_W]     = op;
    req_a[idx*DATA_W +: DATA_W]  = a;
    req_b[idx*DATA_W +: DATA_W]  = b;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One isolated request with rsp_ready high; operands are scrambled after accept.
  task automatic run_op(input int id, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res,
                        input logic exp_zero, input logic exp_err, input string tag);
    rsp_ready = 1'b1;
    applyStimulus(id, 1'b1, op, a, b);
    #1;
    checkOutput({tag, "_ready"}, 32'(req_ready), 32'(1 << id));
    step();
    applyStimulus(id, 1'b0, 4'hE, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    #1;
    checkOutput({tag, "_issue_ready"}, 32'(req_ready), 32'h0);
    checkOutput({tag, "_issue_busy"}, 32'(busy), 32'h1);
    checkOutput({tag, "_alu_ctrl"}, 32'(alu_ctrl), 32'(op));
    checkOutput({tag, "_alu_a"}, alu_a, a);
    checkOutput({tag, "_alu_b"}, alu_b, b);
    step();
    checkOutput({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h1);
    checkOutput({tag, "_rsp_id"}, 32'(rsp_id), 32'(id));
    checkOutput({tag, "_rsp_result"}, rsp_result, exp_res);
    checkOutput({tag, "_rsp_zero"}, 32'(rsp_zero), 32'(exp_zero));
    checkOutput({tag, "_rsp_err"}, 32'(rsp_err), 32'(exp_err));
    step();
    checkOutput({tag, "_done_valid"}, 32'(rsp_valid), 32'h0);
    checkOutput({tag, "_done_busy"}, 32'(busy), 32'h0);
  endtask

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    #12;
    checkOutput("reset_req_ready", 32'(req_ready), 32'h0);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    checkOutput("reset_busy", 32'(busy), 32'h0);
    checkOutput("reset_op_count", 32'(op_count), 32'h0);
    checkOutput("reset_alu_ctrl", 32'(alu_ctrl), 32'h0);
    checkOutput("reset_alu_a", alu_a, 32'h0);
    checkOutput("reset_rsp_id", 32'(rsp_id), 32'h0);
    checkOutput("reset_rsp_result", rsp_result, 32'h0);
    checkOutput("reset_rsp_err", 32'(rsp_err), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    step();

    run_op(2, 4'b0001, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0, "single");
    checkOutput("single_op_count", 32'(op_count), 32'd1);
    run_op(3, 4'b0011, 32'd6, 32'd7, 32'd42, 1'b0, 1'b0, "mul");
    checkOutput("mul_op_count", 32'(op_count), 32'd2);

    // Round robin: last grant is 3, so order must be 0,1,2,3,0.
    rsp_ready = 1'b1;
    for (int i = 0; i < NUM_REQ; i++)
      applyStimulus(i, 1'b1, 4'b0010, 32'(100 * (i + 1)), 32'(i + 1));
    for (int g = 0; g < 5; g++) begin
      exp_id = g % NUM_REQ;
      #1;
      checkOutput("rr_grant", 32'(req_ready), 32'(1 << exp_id));
      step();
      checkOutput("rr_issue_ready", 32'(req_ready), 32'h0);
      step();
      checkOutput("rr_rsp_valid", 32'(rsp_valid), 32'h1);
      checkOutput("rr_rsp_id", 32'(rsp_id), 32'(exp_id));
      checkOutput("rr_rsp_result", rsp_result, 32'(99 * (exp_id + 1)));
      step();
    end
    req_valid = '0;
    #1;
    checkOutput("rr_op_count", 32'(op_count), 32'd7);

    // Backpressure with requester 0 waiting behind requester 1.
    rsp_ready = 1'b0;
    applyStimulus(0, 1'b1, 4'b0001, 32'd1, 32'd1);
    applyStimulus(1, 1'b1, 4'b0001, 32'd10, 32'd20);
    #1;
    checkOutput("bp_grant", 32'(req_ready), 32'b0010);
    step();
    applyStimulus(1, 1'b0, 4'h0, 32'd0, 32'd0);
    step();
    checkOutput("bp_rsp_valid", 32'(rsp_valid), 32'h1);
    checkOutput("bp_rsp_result", rsp_result, 32'd30);
    for (int c = 0; c < 5; c++) begin
      step();
      checkOutput("bp_hold_valid", 32'(rsp_valid), 32'h1);
      checkOutput("bp_hold_id", 32'(rsp_id), 32'd1);
      checkOutput("bp_hold_result", rsp_result, 32'd30);
      checkOutput("bp_hold_busy", 32'(busy), 32'h1);
      checkOutput("bp_hold_ready", 32'(req_ready), 32'h0);
    end
    rsp_ready = 1'b1;
    step();
    checkOutput("bp_release_valid", 32'(rsp_valid), 32'h0);
    checkOutput("bp_op_count", 32'(op_count), 32'd8);
    checkOutput("bp_next_grant", 32'(req_ready), 32'b0001);
    applyStimulus(0, 1'b0, 4'h0, 32'd0, 32'd0);
    #1;

    run_op(0, 4'b0100, 32'd9, 32'd0, 32'd0, 1'b1, 1'b1, "divzero");
    run_op(1, 4'b1111, 32'd3, 32'd4, 32'd0, 1'b1, 1'b1, "illegal_f");
    run_op(2, 4'b0000, 32'd3, 32'd4, 32'd0, 1'b1, 1'b1, "illegal_0");
    run_op(3, 4'b0111, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'd0, 1'b1, 1'b0, "zero");
    run_op(0, 4'b0100, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0, "div");
    checkOutput("screen_op_count", 32'(op_count), 32'd13);

    // Reset while a response is pending in RESP.
    rsp_ready = 1'b0;
    applyStimulus(1, 1'b1, 4'b0001, 32'd1, 32'd1);
    step();
    applyStimulus(1, 1'b0, 4'h0, 32'd0, 32'd0);
    step();
    checkOutput("rst_pre_valid", 32'(rsp_valid), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    checkOutput("rst_op_count", 32'(op_count), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_rsp_result", rsp_result, 32'h0);
    checkOutput("rst_rsp_id", 32'(rsp_id), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NUM_REQ; i++)
      applyStimulus(i, 1'b1, 4'b0001, 32'd2, 32'd2);
    #1;
    checkOutput("rst_first_grant", 32'(req_ready), 32'b0001);
    req_valid = '0;
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Shares one combinational 32-bit ALU instance among NUM_REQ requesters, e.g. NoC tile cores or pipeline units, using round-robin arbitration. Each requester presents an opcode and two operands on a valid/ready channel. The arbiter registers the winning request, drives the ALU for one cycle, and captures the result and zero flag. It returns them on a single response channel tagged with the requester ID. It also screens opcodes the ALU cannot execute meaningfully: illegal codes and divide-by-zero.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
DATA_W, 32, operand/result width; must match the ALU
OP_W, 4, ALU control code width
ID_W, 2, requester ID width, equal to clog2(NUM_REQ)
CNT_W, 16, completed-operation counter width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester accept; at most one bit high
req_op  in  NUM_REQ*OP_W  packed opcodes, requester i at [i*OP_W +: OP_W]
req_a  in  NUM_REQ*DATA_W  packed operand A
req_b  in  NUM_REQ*DATA_W  packed operand B
alu_ctrl  out  OP_W  to ALU control input
alu_a  out  DATA_W  to ALU first operand
alu_b  out  DATA_W  to ALU second operand
alu_result  in  DATA_W  from ALU result
alu_zero  in  1  from ALU ZERO flag
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumer ready
rsp_id  out  ID_W  requester ID of the response
rsp_result  out  DATA_W  captured result
rsp_zero  out  1  captured zero flag
rsp_err  out  1  illegal opcode or divide-by-zero
busy  out  1  high whenever state is not IDLE
op_count  out  CNT_W  count of completed responses; wraps

Behaviour:
- Reset values: state IDLE, req_ready 0, alu_ctrl/alu_a/alu_b 0, rsp_valid 0, rsp_id 0, rsp_result 0, rsp_zero 0, rsp_err 0, busy 0, op_count 0, priority pointer last_grant = NUM_REQ-1, so requester 0 wins first.
- FSM has three states: IDLE, ISSUE, RESP.
- IDLE, arbitration:
  - If any req_valid is high, the winner is the first valid index searching from last_grant+1 upward, modulo NUM_REQ.
  - req_ready[winner] = 1 combinationally, only in IDLE. All other req_ready bits are 0.
  - On the clock edge, latch op/a/b/id of the winner into registers and go to ISSUE.
  - With no req_valid high, stay in IDLE.
- ISSUE, exactly one cycle:
  - alu_ctrl/alu_a/alu_b are driven from the latched registers.
  - In every state other than ISSUE, alu_ctrl = 0 and the operand outputs hold 0.
  - At the end of the cycle, capture alu_result/alu_zero into the rsp registers, set rsp_valid = 1, and go to RESP.
- Screening:
  - Opcodes 0000 and 1111 are illegal.
  - Opcode 0100 with latched B == 0 is divide-by-zero.
  - In either case the ALU is still driven, but the arbiter captures rsp_result = 0, rsp_zero = 1, rsp_err = 1.
  - Otherwise rsp_err = 0.
- RESP:
  - Hold rsp_* stable while rsp_valid && !rsp_ready.
  - On rsp_valid && rsp_ready: clear rsp_valid, set last_grant = rsp_id, increment op_count (wraps to 0 from all ones), go to IDLE.
- Latency and throughput:
  - Request acceptance to rsp_valid is 2 cycles: accept edge, then ISSUE edge.
  - Peak throughput is one operation per 3 cycles with rsp_ready held high.
- A requester's inputs may change after its accept cycle; the arbiter uses only the latched copy.
- A requester that drops req_valid before being granted is simply skipped. There is no starvation: every continuously valid requester is granted within NUM_REQ grants.
- Asserting rst mid-operation (ISSUE or RESP) abandons the transaction. No response is produced, and all outputs return to their reset values immediately.
- Packed requester slices above NUM_REQ are not used. rsp_id never exceeds NUM_REQ-1.

Test Plan:
- Single request: req 2 sends op 0001, A=5, B=7, rsp_ready=1 -> req_ready[2] for 1 cycle; 2 cycles later rsp_valid=1, rsp_id=2, rsp_result=12, rsp_zero=0, rsp_err=0, op_count=1.
- Round-robin fairness: all 4 requesters valid continuously with distinct op 0010 operands -> grant order 0,1,2,3,0; each rsp_id matches; no req_ready overlap.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_* stable, busy=1, no req_ready asserted; rsp_ready=1 -> one handshake, then IDLE.
- Screening: op 0100 with A=9, B=0 -> rsp_result=0, rsp_zero=1, rsp_err=1. Op 1111 -> same outputs. Op 0011, A=6, B=7 -> rsp_result=42, rsp_err=0.
- Zero flag: op 0111 with A=B=0xA5A5A5A5 -> rsp_result=0, rsp_zero=1, rsp_err=0.
- Reset mid-op: assert rst during RESP -> rsp_valid=0 asynchronously, op_count=0; after release, first grant goes to requester 0.
